// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: bundles the hazard-controller inputs and pipeline control outputs.
//   master: pipeline side (drives ID/EX/MEM status and perf_clr, receives control).
//   slave : controller side (receives status, drives enables/flushes/state/counters).
interface pipe_hazard_ctrl_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_rn, id_rm, ex_rd;
    logic             id_use_rn, id_use_rm, ex_mem_read, branch_taken, mem_busy, perf_clr;
    logic             pc_we, if_id_we, if_id_flush, id_ex_flush, pipe_freeze;
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;

    modport master (
        output id_rn, id_rm, ex_rd, id_use_rn, id_use_rm, ex_mem_read,
               branch_taken, mem_busy, perf_clr,
        input  pc_we, if_id_we, if_id_flush, id_ex_flush, pipe_freeze,
               ctrl_state, stall_cnt, flush_cnt, freeze_cnt
    );

    modport slave (
        input  id_rn, id_rm, ex_rd, id_use_rn, id_use_rm, ex_mem_read,
               branch_taken, mem_busy, perf_clr,
        output pc_we, if_id_we, if_id_flush, id_ex_flush, pipe_freeze,
               ctrl_state, stall_cnt, flush_cnt, freeze_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use / branch / memory-busy sequencing for IF, IF/ID and ID/EX.
//   clk, reset : clock, synchronous active-high reset
//   bus (slave): hazard inputs, PC/IF-ID enables, flushes, freeze, ctrl_state, perf counters
//   Perf counters exist only when HAZARD_PERF_CNT_EN is defined; otherwise they read 0.
module pipe_hazard_ctrl #(
    parameter int REG_W           = 4,
    parameter int LOAD_USE_CYCLES = 1,
    parameter int FLUSH_CYCLES    = 1,
    parameter int CNT_W           = 16
) (
    input logic               clk,
    input logic               reset,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;

    localparam logic [3:0] STALL_REM = 4'(LOAD_USE_CYCLES - 1);
    localparam logic [3:0] FLUSH_REM = 4'(FLUSH_CYCLES - 1);

    state_t           state, state_n;
    logic [3:0]       remain, remain_n;
    logic [REG_W-1:0] rn, rm, rd;
    logic             hz;

    assign rn = bus.id_rn;
    assign rm = bus.id_rm;
    assign rd = bus.ex_rd;
    assign hz = bus.ex_mem_read & ((bus.id_use_rn & (rn == rd)) | (bus.id_use_rm & (rm == rd)));
    assign bus.ctrl_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= RUN;
            remain <= 4'd0;
        end else begin
            state  <= state_n;
            remain <= remain_n;
        end
    end

    always_comb begin
        bus.pc_we       = 1'b1;
        bus.if_id_we    = 1'b1;
        bus.if_id_flush = 1'b0;
        bus.id_ex_flush = 1'b0;
        bus.pipe_freeze = 1'b0;
        state_n         = state;
        remain_n        = remain;
        if (reset) begin
            bus.pc_we       = 1'b0;
            bus.if_id_we    = 1'b0;
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
        end else if (bus.mem_busy) begin
            bus.pipe_freeze = 1'b1;
            bus.pc_we       = 1'b0;
            bus.if_id_we    = 1'b0;
        end else if (bus.branch_taken) begin
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
            state_n         = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            remain_n        = FLUSH_REM;
        end else if (state == STALL || (state == RUN && hz)) begin
            bus.pc_we       = 1'b0;
            bus.if_id_we    = 1'b0;
            bus.id_ex_flush = 1'b1;
            if (state == STALL) begin
                remain_n = remain - 4'd1;
                state_n  = (remain == 4'd1) ? RUN : STALL;
            end else if (LOAD_USE_CYCLES > 1) begin
                state_n  = STALL;
                remain_n = STALL_REM;
            end
        end else if (state == FLUSH) begin
            // Sequential fetch continues while the wrong-path slots are cleared.
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
            remain_n        = remain - 4'd1;
            state_n         = (remain == 4'd1) ? RUN : FLUSH;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q, freeze_q;
    logic             stall_inc, flush_inc;

    // Stall cycles are the only ones bubbling ID/EX without clearing IF/ID.
    assign stall_inc = bus.id_ex_flush & ~bus.if_id_flush;
    assign flush_inc = bus.if_id_flush & ~reset;

    always_ff @(posedge clk) begin
        if (reset || bus.perf_clr) begin
            stall_q  <= '0;
            flush_q  <= '0;
            freeze_q <= '0;
        end else begin
            if (stall_inc && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
            if (flush_inc && !(&flush_q)) flush_q <= flush_q + CNT_W'(1);
            if (bus.pipe_freeze && !(&freeze_q)) freeze_q <= freeze_q + CNT_W'(1);
        end
    end

    assign bus.stall_cnt  = stall_q;
    assign bus.flush_cnt  = flush_q;
    assign bus.freeze_cnt = freeze_q;
`else
    assign bus.stall_cnt  = {CNT_W{1'b0}};
    assign bus.flush_cnt  = {CNT_W{1'b0}};
    assign bus.freeze_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for two controller configurations against an action-level model.
module tb_pipe_hazard_ctrl;
    localparam int LA = 1, FA = 1, LB = 3, FB = 4;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic       rst;
        logic [3:0] rn, rm, rd;
        logic       urn, urm, mr, br, mb, clr;
    } stim_t;
    typedef logic [54:0] obs_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_W(4), .CNT_W(16)) ba ();
    pipe_hazard_ctrl_if #(.REG_W(4), .CNT_W(16)) bb ();

    pipe_hazard_ctrl #(.REG_W(4), .LOAD_USE_CYCLES(LA), .FLUSH_CYCLES(FA), .CNT_W(16))
        dut_a (.clk(clk), .reset(reset), .bus(ba.slave));
    pipe_hazard_ctrl #(.REG_W(4), .LOAD_USE_CYCLES(LB), .FLUSH_CYCLES(FB), .CNT_W(16))
        dut_b (.clk(clk), .reset(reset), .bus(bb.slave));

    int   tests = 0, fails = 0, cyc = 0;
    int   mode[2], left[2], sc[2], fc[2], zc[2];
    obs_t qa[$], qb[$];

    // Action per cycle: 0 run, 1 stall, 2 flush/branch, 3 freeze, 4 reset.
    task automatic model(input int k, input stim_t s, output obs_t o);
        int  nl = k ? LB : LA;
        int  nf = k ? FB : FA;
        int  a;
        bit  hz = s.mr && ((s.urn && s.rn == s.rd) || (s.urm && s.rm == s.rd));
        logic [1:0]  st = 2'(mode[k]);
        logic [15:0] es = PERF ? 16'(sc[k]) : 16'd0;
        logic [15:0] ef = PERF ? 16'(fc[k]) : 16'd0;
        logic [15:0] ez = PERF ? 16'(zc[k]) : 16'd0;
        if (s.rst) a = 4;
        else if (s.mb) a = 3;
        else if (s.br) begin
            a = 2; left[k] = nf - 1; mode[k] = (left[k] > 0) ? 2 : 0;
        end else if (mode[k] != 0) begin
            a = mode[k]; left[k]--; if (left[k] == 0) mode[k] = 0;
        end else if (hz) begin
            a = 1; left[k] = nl - 1; mode[k] = (left[k] > 0) ? 1 : 0;
        end else a = 0;
        o = {(a == 0 || a == 2), (a == 0 || a == 2), (a == 2 || a == 4),
             (a == 1 || a == 2 || a == 4), (a == 3), st, es, ef, ez};
        if (s.rst) begin
            mode[k] = 0; left[k] = 0; sc[k] = 0; fc[k] = 0; zc[k] = 0;
        end else if (s.clr) begin
            sc[k] = 0; fc[k] = 0; zc[k] = 0;
        end else begin
            if (a == 1 && sc[k] < 65535) sc[k]++;
            if (a == 2 && fc[k] < 65535) fc[k]++;
            if (a == 3 && zc[k] < 65535) zc[k]++;
        end
    endtask

    task automatic apply(input stim_t s);
        reset = s.rst;
        {ba.id_rn, ba.id_rm, ba.ex_rd} = {s.rn, s.rm, s.rd};
        {bb.id_rn, bb.id_rm, bb.ex_rd} = {s.rn, s.rm, s.rd};
        {ba.id_use_rn, ba.id_use_rm, ba.ex_mem_read, ba.branch_taken, ba.mem_busy, ba.perf_clr} =
            {s.urn, s.urm, s.mr, s.br, s.mb, s.clr};
        {bb.id_use_rn, bb.id_use_rm, bb.ex_mem_read, bb.branch_taken, bb.mem_busy, bb.perf_clr} =
            {s.urn, s.urm, s.mr, s.br, s.mb, s.clr};
    endtask

    task automatic step(input stim_t s);
        obs_t oa, ob;
        @(posedge clk);
        #1;
        apply(s);
        model(0, s, oa);
        model(1, s, ob);
        qa.push_back(oa);
        qb.push_back(ob);
    endtask

    function automatic stim_t mk(input bit rst, input logic [3:0] rn, rm, rd,
                                 input bit urn, urm, mr, br, mb, clr);
        return '{rst, rn, rm, rd, urn, urm, mr, br, mb, clr};
    endfunction

    function automatic obs_t grab(input int k);
        return k ? {bb.pc_we, bb.if_id_we, bb.if_id_flush, bb.id_ex_flush, bb.pipe_freeze,
                    bb.ctrl_state, bb.stall_cnt, bb.flush_cnt, bb.freeze_cnt}
                 : {ba.pc_we, ba.if_id_we, ba.if_id_flush, ba.id_ex_flush, ba.pipe_freeze,
                    ba.ctrl_state, ba.stall_cnt, ba.flush_cnt, ba.freeze_cnt};
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got ctl=%b st=%0d cnt=%h expected ctl=%b st=%0d cnt=%h",
                     name, cyc, got[54:50], got[49:48], got[47:0], exp[54:50], exp[49:48], exp[47:0]);
        end
    endtask

    always @(negedge clk) begin
        if (qa.size() != 0) begin
            check("ctl_a", grab(0), qa.pop_front());
            check("ctl_b", grab(1), qb.pop_front());
            cyc++;
        end
    end

    initial begin
        stim_t idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            mode[k] = 0; left[k] = 0; sc[k] = 0; fc[k] = 0; zc[k] = 0;
        end
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(idle);
        step(mk(0, 3, 0, 3, 1, 0, 1, 0, 0, 0));
        repeat (4) step(idle);
        step(mk(0, 0, 3, 3, 0, 0, 1, 0, 0, 0));
        step(mk(0, 7, 3, 3, 1, 0, 1, 0, 0, 0));
        repeat (3) step(idle);
        step(mk(0, 5, 0, 5, 1, 0, 1, 0, 0, 0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        repeat (3) step(idle);
        repeat (4) step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        repeat (5) step(idle);
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (3) step(idle);
        step(mk(0, 15, 15, 15, 1, 1, 1, 0, 0, 0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        repeat (4) step(idle);
        for (int i = 0; i < 800; i++) begin
            stim_t s;
            s.rst = ($urandom % 80) == 0;
            s.rn  = 4'($urandom % 4);
            s.rm  = 4'($urandom % 4);
            s.rd  = 4'($urandom % 4);
            s.urn = 1'($urandom);
            s.urm = 1'($urandom);
            s.mr  = 1'($urandom);
            s.br  = ($urandom % 7) == 0;
            s.mb  = ($urandom % 6) == 0;
            s.clr = ($urandom % 60) == 0;
            step(s);
        end
        @(posedge clk);
        #1;
        apply(idle);
        @(negedge clk);
        #1;
        tests++;
        if (qa.size() != 0 || qb.size() != 0) begin
            fails++;
            $display("FAIL drain got=%0d expected=0 entries left", qa.size() + qb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the ID/EX control register and its neighbours. Detects load-use hazards, taken-branch redirects and memory-busy conditions. Drives the write-enables and flushes that stall, bubble or freeze the IF, IF/ID and ID/EX stages. `id_ex_flush` is ORed into the ID/EX register's synchronous reset to inject a bubble (all EX/MEM/WB control = 0).

## Interface
- `REG_W`, 4, register-index width
- `LOAD_USE_CYCLES`, 1, bubbles inserted per load-use hazard (1..15)
- `FLUSH_CYCLES`, 1, cycles IF/ID and ID/EX are flushed per taken branch (1..15)
- `CNT_W`, 16, performance counter width

- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `id_rn`, `id_rm`  in  REG_W each  source registers of instruction in ID
- `id_use_rn`, `id_use_rm`  in  1 each  source is actually read
- `ex_rd`  in  REG_W  destination of instruction in EX
- `ex_mem_read`  in  1  EX instruction is a load
- `branch_taken`  in  1  EX resolved a taken branch this cycle
- `mem_busy`  in  1  MEM stage cannot complete this cycle
- `perf_clr`  in  1  clear performance counters
- `pc_we`, `if_id_we`  out  1 each  PC / IF/ID write enables
- `if_id_flush`  out  1  clear IF/ID to NOP
- `id_ex_flush`  out  1  clear ID/EX control fields (bubble)
- `pipe_freeze`  out  1  hold all stage registers (ID/EX and later)
- `ctrl_state`  out  2  current state: 0 RUN, 1 STALL, 2 FLUSH
- `stall_cnt`, `flush_cnt`, `freeze_cnt`  out  CNT_W each  performance counters

## Operation
- Registered: `ctrl_state`, 4-bit `remain` counter, perf counters. All other outputs are combinational from state, `remain` and inputs.
- Hazard: `hz = ex_mem_read & ((id_use_rn & id_rn==ex_rd) | (id_use_rm & id_rm==ex_rd))`.
- Priority each cycle: `reset` > `mem_busy` > `branch_taken` > state action > `hz`.
- `reset` cycle:
  - Outputs: `pc_we=0`, `if_id_we=0`, `if_id_flush=1`, `id_ex_flush=1`, `pipe_freeze=0`.
  - Next: RUN, `remain=0`, counters 0.
- `mem_busy` (any state): `pipe_freeze=1`, `pc_we=if_id_we=0`, no flushes. State and `remain` hold. `freeze_cnt++`.
- `branch_taken` (any state, not frozen):
  - Outputs: `pc_we=1`, `if_id_we=1`, `if_id_flush=1`, `id_ex_flush=1`. `flush_cnt++`.
  - If `FLUSH_CYCLES>1`: next FLUSH, `remain=FLUSH_CYCLES-1`. Otherwise next RUN.
  - An active STALL is aborted.
- RUN:
  - `hz`: `pc_we=if_id_we=0`, `id_ex_flush=1`, `stall_cnt++`. If `LOAD_USE_CYCLES>1`: next STALL, `remain=LOAD_USE_CYCLES-1`.
  - Else: `pc_we=if_id_we=1`, no flushes.
- STALL: outputs as RUN-with-`hz`, `stall_cnt++`, `remain--`. At `remain==1` the next state is RUN.
- FLUSH: outputs as branch cycle, except `pc_we=1` with PC advancing sequentially. `flush_cnt++`, `remain--`. At `remain==1` the next state is RUN.
- Counters saturate at `2^CNT_W-1`. `perf_clr` zeroes them at the clock edge and overrides any increment in the same cycle.
- Register indices compare at full `REG_W`. Index 15 (PC) is not special-cased.

## Timing
- Hazard response is zero-latency: the bubble enters ID/EX on the same edge the hazard is seen.
- With the default parameters, a load-use costs exactly 1 cycle. At the next edge EX holds a bubble, so `hz` deasserts.
- Branch flush is the same cycle `branch_taken` is high. The next fetch is at the target.
- `mem_busy` freezes with no latency. Resume is on the first cycle it drops, from the held state.
- Reset mid-STALL or mid-FLUSH: the next cycle is RUN with `remain=0`. There is no residual stall.

## Configuration
- `HAZARD_PERF_CNT_EN` defined: `stall_cnt`, `flush_cnt` and `freeze_cnt` are implemented as described.
- Not defined: the counter registers are removed, the three outputs are tied to 0, `perf_clr` is ignored, and control behaviour is identical.

## Test plan
- **Load-use:** `ex_mem_read=1`, `ex_rd=3`, `id_rn=3`, `id_use_rn=1` for one cycle. Expect `pc_we=0`, `if_id_we=0`, `id_ex_flush=1`, `stall_cnt=1`. Next cycle (EX bubble) returns to `pc_we=1`.
- **No false hazard:** `ex_rd=3`, `id_rm=3`, `id_use_rm=0`, `ex_mem_read=1`. Expect no stall and `stall_cnt=0`.
- **Multi-cycle stall:** `LOAD_USE_CYCLES=3`, hazard held 1 cycle. Expect 3 consecutive stall cycles with `ctrl_state` 0→1→1→0 and `stall_cnt=3`.
- **Branch aborts stall:** `LOAD_USE_CYCLES=3`, `branch_taken` on the 2nd stall cycle. Expect `if_id_flush=id_ex_flush=1`, `pc_we=1`, then RUN. `flush_cnt=1`.
- **Freeze over branch:** `mem_busy=1` with `branch_taken=1` for 4 cycles. Expect `pipe_freeze=1`, no flush, `freeze_cnt=4`. On `mem_busy=0` the flush occurs that cycle.
- **Reset during FLUSH:** `FLUSH_CYCLES=4`, `reset` asserted on the 2nd flush cycle. Expect `if_id_flush=id_ex_flush=1` during reset, `ctrl_state=0` and all counters 0 after.
